dregs_ctrl: RTL and testbench
=============================

# dregs_ctrl

Sequencer for the FoFIR partial-sum delay-register bank (DRegs) inside a PE. Per input activation it drives the DRegs read-select to the PAMAC tap by tap, writes each PAMAC result back into the register it was read from, then hands the completed sum downstream with a valid/ready handshake. Finally it rotates the register ring so the next output's partial sums line up. It owns all DRegs control signals; the DRegs datapath and the PAMAC sit beside it in the PE.

## Interface
- `nb_taps`, 5: number of taps and DRegs; legal values 5, 7, 11.
- `width_current_tap`, `nb_taps > 8 ? 4 : 3`: width of the tap select.
- `PAMAC_LAT`, 2: cycles from `pamac_issue` to the PAMAC result being valid at the DRegs input; must be ≥1.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a new activation is ready for PAMAC.
- `in_ready` out 1: controller accepts an activation.
- `clear_all` in 1: abort the pass and zero all DRegs.
- `pamac_issue` out 1: PAMAC consumes `DRegs_out` for the current tap this cycle.
- `current_tap_DRegs` out `width_current_tap`: DRegs output mux select.
- `DRegs_en` out `nb_taps`: per-register load enable.
- `DRegs_clr` out `nb_taps`: per-register synchronous clear.
- `DRegs_in_sel` out `nb_taps`: per-register input select; 0 = left neighbour, 1 = PAMAC result.
- `out_valid` out 1: `DRegs_out` holds a finished output (tap `nb_taps-1`).
- `out_ready` in 1: downstream takes the output.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, EMIT, ROTATE.
- **IDLE**
  - `in_ready`=1.
  - `in_valid` → ISSUE with `tap_cnt`=0.
- **ISSUE**
  - Each cycle: `current_tap_DRegs`=`tap_cnt` and `pamac_issue`=1, and {1,`tap_cnt`} is pushed into the write-back delay line.
  - After tap `nb_taps-1` → DRAIN.
- **Write-back delay line**
  - `PAMAC_LAT` stages of {valid, tap}.
  - When a valid entry emerges with tap t, in that same cycle: `DRegs_en[t]`=1 and `DRegs_in_sel[t]`=1.
  - Write-backs overlap ISSUE; the tap being read never equals the tap being written.
- **DRAIN**
  - Wait until the delay line is empty → EMIT.
- **EMIT**
  - `out_valid`=1 and `current_tap_DRegs`=`nb_taps-1`; hold until `out_ready`.
  - On handshake → ROTATE.
- **ROTATE** (one cycle)
  - `DRegs_clr[0]`=1.
  - For i≥1: `DRegs_en[i]`=1 and `DRegs_in_sel[i]`=0 (shift left-to-right).
  - Then → IDLE.
- **clear_all**
  - In any state, `clear_all` wins over everything.
  - `DRegs_clr` is all ones and `DRegs_en` is zero that cycle.
  - The delay line is flushed, `tap_cnt`=0, and the FSM → IDLE.
  - In IDLE it also takes precedence over `in_valid`; the activation is not accepted.
- **Invariant:** `DRegs_en[i]` and `DRegs_clr[i]` are never both 1.
- **Defaults**
  - All strobes are 0 when not stated.
  - `DRegs_in_sel` is 0 when not stated.
  - `current_tap_DRegs` is 0 in IDLE, DRAIN and ROTATE.
- **Reset values**
  - FSM = IDLE and the delay line is empty.
  - All outputs are 0, except `in_ready`=1.

## Timing
- Accept at cycle 0 (IDLE with `in_valid`=1).
- Tap t is issued at cycle 1+t and written back at cycle 1+t+`PAMAC_LAT`.
- EMIT starts at cycle `nb_taps`+`PAMAC_LAT`+1.
- Default parameters with `out_ready`=1:
  - EMIT at cycle 8, ROTATE at 9, IDLE at 10.
  - One output per 10 cycles.
- All outputs are registered-state decodes (Moore); no combinational path from `in_valid`/`out_ready` to `DRegs_*`.
- `rst_n` asserted mid-pass: outputs return to reset values immediately. DRegs contents are the datapath's concern; they are also reset by `rst_n`.

## Configuration
- `DREGS_CTRL_PERF_EN` defined:
  - Adds output `perf_pass_cnt` (16 bit, increments on each EMIT handshake, wraps at 0xFFFF→0).
  - Adds output `perf_stall_cnt` (16 bit, counts EMIT cycles with `out_ready`=0, saturates at 0xFFFF).
  - Both clear on `rst_n` and on `clear_all`.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Package `dregs_ctrl_pkg`:
  - State enum and its encoding.
  - Write-back entry struct {valid, tap}.
  - Constant legal `nb_taps` set.
- One sub-module, `dregs_wb_delay`: a parameterised `PAMAC_LAT`-deep shift register of write-back entries, with a flush input and an empty flag.

## Test plan
- **Reset:** `rst_n` low → `in_ready`=1; `DRegs_en`/`DRegs_clr`/`DRegs_in_sel`/`pamac_issue`/`out_valid` = 0; `current_tap_DRegs`=0.
- **Single pass, defaults, `out_ready`=1:**
  - `in_valid` at cycle 0 → `pamac_issue` at cycles 1–5 with taps 0–4.
  - `DRegs_en`=00001…10000 with `DRegs_in_sel` matching at cycles 3–7.
  - `out_valid` at cycle 8; ROTATE at 9 with `DRegs_en`=11110, `DRegs_clr`=00001; `in_ready` at 10.
- **Back-pressure:** `out_ready`=0 for 4 cycles in EMIT → `out_valid` held with `current_tap_DRegs`=4; ROTATE occurs the cycle after `out_ready`=1.
- **clear_all mid-ISSUE (tap 2):** next cycle `DRegs_clr`=11111, `DRegs_en`=0, FSM IDLE; no further write-back fires.
- **Parameter sweep:** `nb_taps`=11, `PAMAC_LAT`=1 → `current_tap_DRegs` 4-bit 0–10; EMIT at cycle 13; en/clr never both high (checked every cycle).
- **Perf (`DREGS_CTRL_PERF_EN`):** 3 passes with 2 stall cycles each → `perf_pass_cnt`=3, `perf_stall_cnt`=6.

Source files
------------

// File: rtl/dregs_ctrl_pkg.sv
// Shared types for the DRegs sequencer: FSM encoding, write-back entry, legal bank sizes.
package dregs_ctrl_pkg;

  localparam int unsigned TAP_W_MAX      = 4;
  localparam int unsigned NB_TAPS_LEGAL_N = 3;
  localparam int unsigned NB_TAPS_LEGAL [NB_TAPS_LEGAL_N] = '{5, 7, 11};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_EMIT   = 3'd3,
    ST_ROTATE = 3'd4
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAP_W_MAX-1:0] tap;
  } wb_entry_t;

  function automatic bit nb_taps_legal(input int unsigned n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < int'(NB_TAPS_LEGAL_N); i++) begin
      if (NB_TAPS_LEGAL[i] == n) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dregs_ctrl_if.sv
// Control bundle between the DRegs sequencer (master) and the PE datapath / upstream / downstream (slave).
interface dregs_ctrl_if #(
  parameter int unsigned nb_taps           = 5,
  parameter int unsigned width_current_tap = (nb_taps > 8) ? 4 : 3
);

  logic                         in_valid;
  logic                         in_ready;
  logic                         clear_all;
  logic                         pamac_issue;
  logic [width_current_tap-1:0] current_tap_DRegs;
  logic [nb_taps-1:0]           DRegs_en;
  logic [nb_taps-1:0]           DRegs_clr;
  logic [nb_taps-1:0]           DRegs_in_sel;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    input  in_valid, clear_all, out_ready,
    output in_ready, pamac_issue, current_tap_DRegs,
           DRegs_en, DRegs_clr, DRegs_in_sel, out_valid
  );

  modport slave (
    output in_valid, clear_all, out_ready,
    input  in_ready, pamac_issue, current_tap_DRegs,
           DRegs_en, DRegs_clr, DRegs_in_sel, out_valid
  );

endinterface

// File: rtl/dregs_wb_delay.sv
// PAMAC_LAT-deep shift line of write-back entries; head is the entry landing in DRegs this cycle.
// empty: no entry will remain in flight after the coming clock edge.
module dregs_wb_delay
  import dregs_ctrl_pkg::*;
#(
  parameter int unsigned PAMAC_LAT = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  wb_entry_t push,
  output wb_entry_t head,
  output logic      empty
);

  wb_entry_t stage_q [PAMAC_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PAMAC_LAT); i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(PAMAC_LAT); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push;
      for (int i = 1; i < int'(PAMAC_LAT); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head = stage_q[PAMAC_LAT-1];

  // Head leaves on this edge, so only the younger stages and the incoming push matter.
  always_comb begin
    empty = !push.valid;
    for (int i = 0; i < int'(PAMAC_LAT) - 1; i++) begin
      if (stage_q[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/dregs_ctrl.sv
// FoFIR DRegs sequencer: tap-by-tap PAMAC issue, delayed write-back, emit handshake, ring rotate.
// Optional DREGS_CTRL_PERF_EN adds pass/stall performance counters.
module dregs_ctrl
  import dregs_ctrl_pkg::*;
#(
  parameter int unsigned nb_taps           = 5,
  parameter int unsigned width_current_tap = (nb_taps > 8) ? 4 : 3,
  parameter int unsigned PAMAC_LAT         = 2
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef DREGS_CTRL_PERF_EN
  output logic [15:0]  perf_pass_cnt,
  output logic [15:0]  perf_stall_cnt,
`endif
  dregs_ctrl_if.master bus
);

  localparam logic [width_current_tap-1:0] LAST_TAP = width_current_tap'(nb_taps - 1);
  localparam bit CFG_OK = nb_taps_legal(nb_taps) && (PAMAC_LAT >= 1)
                          && (width_current_tap >= $clog2(nb_taps));

  state_t                       state_q, state_d;
  logic [width_current_tap-1:0] tap_cnt_q, tap_cnt_d;
  logic                         clr_q;

  wb_entry_t                    wb_push, wb_head;
  logic                         wb_empty;

  logic                         in_ready_c, pamac_issue_c, out_valid_c;
  logic [width_current_tap-1:0] cur_tap_c;
  logic [nb_taps-1:0]           en_c, clr_c, sel_c;

  // State register; clr_q remembers a clear_all so the bank clear shows as a Moore output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tap_cnt_q <= '0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      clr_q     <= bus.clear_all;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d   = ST_ISSUE;
          tap_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (tap_cnt_q == LAST_TAP) begin
          state_d   = ST_DRAIN;
          tap_cnt_d = '0;
        end else begin
          tap_cnt_d = tap_cnt_q + width_current_tap'(1);
        end
      end
      ST_DRAIN:  if (wb_empty) state_d = ST_EMIT;
      ST_EMIT:   if (bus.out_ready) state_d = ST_ROTATE;
      ST_ROTATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.clear_all) begin
      state_d   = ST_IDLE;
      tap_cnt_d = '0;
    end
  end

  always_comb begin
    wb_push = '0;
    if (state_q == ST_ISSUE) begin
      wb_push.valid = 1'b1;
      wb_push.tap   = TAP_W_MAX'(tap_cnt_q);
    end
  end

  dregs_wb_delay #(.PAMAC_LAT(PAMAC_LAT)) u_wb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.clear_all),
    .push  (wb_push),
    .head  (wb_head),
    .empty (wb_empty)
  );

  // Outputs: pure decode of state, emerging write-back entry and pending clear
  always_comb begin
    in_ready_c    = 1'b0;
    pamac_issue_c = 1'b0;
    out_valid_c   = 1'b0;
    cur_tap_c     = '0;
    en_c          = '0;
    clr_c         = '0;
    sel_c         = '0;

    for (int unsigned i = 0; i < nb_taps; i++) begin
      if (wb_head.valid && (wb_head.tap == TAP_W_MAX'(i))) begin
        en_c[i]  = 1'b1;
        sel_c[i] = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE:  in_ready_c = 1'b1;
      ST_ISSUE: begin
        pamac_issue_c = 1'b1;
        cur_tap_c     = tap_cnt_q;
      end
      ST_EMIT: begin
        out_valid_c = 1'b1;
        cur_tap_c   = LAST_TAP;
      end
      ST_ROTATE: begin
        clr_c[0] = 1'b1;
        en_c     = {{(nb_taps-1){1'b1}}, 1'b0};
        sel_c    = '0;
      end
      default: ;
    endcase

    if (clr_q) begin
      en_c  = '0;
      sel_c = '0;
      clr_c = '1;
    end
  end

  assign bus.in_ready          = in_ready_c;
  assign bus.pamac_issue       = pamac_issue_c;
  assign bus.out_valid         = out_valid_c;
  assign bus.current_tap_DRegs = cur_tap_c;
  assign bus.DRegs_en          = en_c;
  assign bus.DRegs_clr         = clr_c;
  assign bus.DRegs_in_sel      = sel_c;

`ifdef DREGS_CTRL_PERF_EN
  // Pass count wraps; stall count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pass_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else if (bus.clear_all) begin
      perf_pass_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else if (state_q == ST_EMIT) begin
      if (bus.out_ready) begin
        perf_pass_cnt <= perf_pass_cnt + 16'd1;
      end else if (perf_stall_cnt != 16'hFFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
    end
  end
`endif

  cfg_legal_a: assert property (@(posedge clk) CFG_OK);
  en_clr_excl_a: assert property (@(posedge clk) disable iff (!rst_n) ((en_c & clr_c) == '0));

endmodule

// File: tb/tb_dregs_ctrl.sv
// Directed self-checking bench for dregs_ctrl: default (5 taps, lat 2) and swept (11 taps, lat 1) instances.
`timescale 1ns/1ps
module tb_dregs_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dregs_ctrl_if #(.nb_taps(5),  .width_current_tap(3)) bus_a ();
  dregs_ctrl_if #(.nb_taps(11), .width_current_tap(4)) bus_b ();

`ifdef DREGS_CTRL_PERF_EN
  logic [15:0] pass_a, stall_a, pass_b, stall_b;
`endif

  dregs_ctrl #(.nb_taps(5), .width_current_tap(3), .PAMAC_LAT(2)) u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DREGS_CTRL_PERF_EN
    .perf_pass_cnt  (pass_a),
    .perf_stall_cnt (stall_a),
`endif
    .bus            (bus_a)
  );

  dregs_ctrl #(.nb_taps(11), .width_current_tap(4), .PAMAC_LAT(1)) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DREGS_CTRL_PERF_EN
    .perf_pass_cnt  (pass_b),
    .perf_stall_cnt (stall_b),
`endif
    .bus            (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot layout: {in_ready, pamac_issue, out_valid, tap, en, clr, in_sel}
  function automatic logic [63:0] exp_a(input logic ir, input logic iss, input logic ov,
                                        input logic [2:0] tap, input logic [4:0] en,
                                        input logic [4:0] clr, input logic [4:0] sel);
    return 64'({ir, iss, ov, tap, en, clr, sel});
  endfunction

  function automatic logic [63:0] obs_a();
    return 64'({bus_a.in_ready, bus_a.pamac_issue, bus_a.out_valid, bus_a.current_tap_DRegs,
                bus_a.DRegs_en, bus_a.DRegs_clr, bus_a.DRegs_in_sel});
  endfunction

  function automatic logic [63:0] exp_b(input logic ir, input logic iss, input logic ov,
                                        input logic [3:0] tap, input logic [10:0] en,
                                        input logic [10:0] clr, input logic [10:0] sel);
    return 64'({ir, iss, ov, tap, en, clr, sel});
  endfunction

  function automatic logic [63:0] obs_b();
    return 64'({bus_b.in_ready, bus_b.pamac_issue, bus_b.out_valid, bus_b.current_tap_DRegs,
                bus_b.DRegs_en, bus_b.DRegs_clr, bus_b.DRegs_in_sel});
  endfunction

  // en and clr of the same register must never be high together
  always @(negedge clk) begin
    chk("en_clr_a", 64'(bus_a.DRegs_en & bus_a.DRegs_clr), 64'd0);
    chk("en_clr_b", 64'(bus_b.DRegs_en & bus_b.DRegs_clr), 64'd0);
  end

  initial begin
    logic [63:0] idle_a, idle_b, emit_a, rot_a;
    logic [3:0]  t_b;
    logic [10:0] e_b;

    idle_a = exp_a(1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b00000);
    emit_a = exp_a(1'b0, 1'b0, 1'b1, 3'd4, 5'b00000, 5'b00000, 5'b00000);
    rot_a  = exp_a(1'b0, 1'b0, 1'b0, 3'd0, 5'b11110, 5'b00001, 5'b00000);
    idle_b = exp_b(1'b1, 1'b0, 1'b0, 4'd0, 11'd0, 11'd0, 11'd0);

    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.clear_all = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.clear_all = 1'b0; bus_b.out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", obs_a(), idle_a);
    chk("reset_b", obs_b(), idle_b);
`ifdef DREGS_CTRL_PERF_EN
    chk("reset_perf", 64'({pass_a, stall_a}), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single pass, out_ready held high; cycle 0 is the accept cycle
    bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    chk("pass1 c0", obs_a(), idle_a);
    tick(); bus_a.in_valid = 1'b0;
    chk("pass1 c1", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b00000)); tick();
    chk("pass1 c2", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd1, 5'b00000, 5'b00000, 5'b00000)); tick();
    chk("pass1 c3", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd2, 5'b00001, 5'b00000, 5'b00001)); tick();
    chk("pass1 c4", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd3, 5'b00010, 5'b00000, 5'b00010)); tick();
    chk("pass1 c5", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd4, 5'b00100, 5'b00000, 5'b00100)); tick();
    chk("pass1 c6", obs_a(), exp_a(1'b0, 1'b0, 1'b0, 3'd0, 5'b01000, 5'b00000, 5'b01000)); tick();
    chk("pass1 c7", obs_a(), exp_a(1'b0, 1'b0, 1'b0, 3'd0, 5'b10000, 5'b00000, 5'b10000)); tick();
    chk("pass1 c8", obs_a(), emit_a); tick();
    chk("pass1 c9", obs_a(), rot_a); tick();
    chk("pass1 c10", obs_a(), idle_a);

    // Back-pressure: 4 stalled EMIT cycles, then handshake
    bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b0;
    tick(); bus_a.in_valid = 1'b0;
    repeat (7) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp stall%0d", i), obs_a(), emit_a);
      tick();
    end
    bus_a.out_ready = 1'b1;
    chk("bp handshake", obs_a(), emit_a); tick();
    bus_a.out_ready = 1'b0;
    chk("bp rotate", obs_a(), rot_a); tick();
    chk("bp idle", obs_a(), idle_a);
`ifdef DREGS_CTRL_PERF_EN
    chk("bp perf_pass", 64'(pass_a), 64'd2);
    chk("bp perf_stall", 64'(stall_a), 64'd4);
`endif

    // clear_all together with in_valid in IDLE: activation not accepted
    bus_a.in_valid = 1'b1; bus_a.clear_all = 1'b1;
    tick(); bus_a.in_valid = 1'b0; bus_a.clear_all = 1'b0;
    chk("clr_idle clr", obs_a(), exp_a(1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b11111, 5'b00000));
`ifdef DREGS_CTRL_PERF_EN
    chk("clr_idle perf", 64'({pass_a, stall_a}), 64'd0);
`endif
    tick();
    chk("clr_idle noaccept", obs_a(), idle_a);

    // clear_all while tap 2 is being issued
    bus_a.in_valid = 1'b1;
    tick(); bus_a.in_valid = 1'b0;
    tick(); tick();
    chk("clr_iss tap2", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd2, 5'b00001, 5'b00000, 5'b00001));
    bus_a.clear_all = 1'b1;
    tick(); bus_a.clear_all = 1'b0;
    chk("clr_iss clr", obs_a(), exp_a(1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b11111, 5'b00000));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("clr_iss after%0d", i), obs_a(), idle_a);
    end

    // rst_n mid-pass returns outputs to reset values without a clock edge
    tick();
    bus_a.in_valid = 1'b1;
    tick(); bus_a.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("rst_mid pre", obs_a(), exp_a(1'b0, 1'b1, 1'b0, 3'd3, 5'b00010, 5'b00000, 5'b00010));
    rst_n = 1'b0;
    #1;
    chk("rst_mid async", obs_a(), idle_a);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid idle", obs_a(), idle_a);

    // Three passes, two stall cycles each
    for (int p = 0; p < 3; p++) begin
      bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b0;
      tick(); bus_a.in_valid = 1'b0;
      repeat (7) tick();
      chk($sformatf("perf p%0d stall0", p), obs_a(), emit_a); tick();
      chk($sformatf("perf p%0d stall1", p), obs_a(), emit_a); tick();
      bus_a.out_ready = 1'b1;
      chk($sformatf("perf p%0d hs", p), obs_a(), emit_a); tick();
      bus_a.out_ready = 1'b0;
      chk($sformatf("perf p%0d rot", p), obs_a(), rot_a); tick();
      chk($sformatf("perf p%0d idle", p), obs_a(), idle_a);
    end
`ifdef DREGS_CTRL_PERF_EN
    chk("perf pass_cnt", 64'(pass_a), 64'd3);
    chk("perf stall_cnt", 64'(stall_a), 64'd6);
`endif

    // Sweep: 11 taps, PAMAC latency 1 -> issue at 1..11, write-back at 2..12, EMIT at 13
    bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
    chk("sweep c0", obs_b(), idle_b);
    tick(); bus_b.in_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      e_b = (c >= 2 && c <= 12) ? (11'd1 << (c - 2)) : 11'd0;
      t_b = (c <= 11) ? 4'(c - 1) : ((c == 13) ? 4'd10 : 4'd0);
      chk($sformatf("sweep c%0d", c), obs_b(),
          exp_b(1'b0, (c <= 11), (c == 13), t_b, e_b, 11'd0, e_b));
      tick();
    end
    chk("sweep rotate", obs_b(), exp_b(1'b0, 1'b0, 1'b0, 4'd0, 11'h7FE, 11'h001, 11'd0));
    tick();
    chk("sweep idle", obs_b(), idle_b);
`ifdef DREGS_CTRL_PERF_EN
    chk("sweep perf_pass", 64'(pass_b), 64'd1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
